mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port valid/ready memory slave (WIDTH=16, DEPTH=64) among NUM_REQ requesters. It sits between the requester agents or masters and the memory interface. It grants one requester at a time, forwards that requester's latched command to the memory, holds it until the memory returns ready, and routes the completion and read data back. Fairness is strict round-robin starting after the last served requester.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_rr_arbiter.sv | 40 ++++
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the round-robin memory arbiter.
//   arb_state_e        : arbiter FSM states (IDLE, ISSUE)
//   DEF_*              : default parameter values used by mem_arbiter and
//                        mem_rr_arbiter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned DEF_NUM_REQ        = 32'd4;
    localparam int unsigned DEF_WIDTH          = 32'd16;
    localparam int unsigned DEF_DEPTH          = 32'd64;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
// Combinational round-robin pick: the first set request bit strictly above
// the last granted position, wrapping around to bit 0.
//   req_i        in   NUM_REQ  request vector
//   last_grant_i in   NUM_REQ  one-hot position of the last served requester
//   grant_o      out  NUM_REQ  one-hot pick (0 when no request)
//   valid_o      out  1        at least one request pending
// ---------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               valid_o
);

    localparam logic [NUM_REQ-1:0] ONE_C = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0] upper_mask_s;
    logic [NUM_REQ-1:0] upper_req_s;

    // Masked priority pick: lowest request above last_grant, else lowest overall.
    // (last << 1) - 1 covers last and everything below it; when last is the top
    // bit the shift wraps to zero and the mask becomes empty, forcing the wrap.
    always_comb begin
        upper_mask_s = ~((last_grant_i << 1'b1) - ONE_C);
        upper_req_s  = req_i & upper_mask_s;
        valid_o      = |req_i;
        if (|upper_req_s) begin
            grant_o = upper_req_s & (~upper_req_s + ONE_C);
        end else begin
            grant_o = req_i & (~req_i + ONE_C);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing one valid/ready memory slave among NUM_REQ
// requesters. One transaction in flight at a time; the granted requester's
// command is latched on grant and held on the memory port until ready_i.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN -- adds an ISSUE watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles without ready_i and flags
// it on req_err_o. Without the macro req_err_o is tied 0.
//
// Ports
//   clk_i, rst_i          clock, async active-high reset
//   req_valid_i/wr_rd_i   per-requester request and direction (1=write)
//   req_addr_i/wdata_i    packed per-requester address / write data
//   req_ready_o           one-cycle completion pulse to the served requester
//   req_rdata_o           read data of the last completed read
//   req_err_o             watchdog abort flag, coincident with req_ready_o
//   valid_o/wr_rd_o/addr_o/wdata_o, ready_i/rdata_i   memory side
//   grant_o               one-hot current owner, 0 when idle
//   busy_o                transaction in flight
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic                          req_err_o,
    output logic                          valid_o,
    output logic                          wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         addr_o,
    output logic [WIDTH-1:0]              wdata_o,
    input  logic                          ready_i,
    input  logic [WIDTH-1:0]              rdata_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam logic [NUM_REQ-1:0] LAST_RST_C = {1'b1, {(NUM_REQ-1){1'b0}}};

    arb_state_e              state_r;
    arb_state_e              state_next_s;
    logic [NUM_REQ-1:0]      pick_s;
    logic                    pick_valid_s;
    logic [NUM_REQ-1:0]      grant_r;
    logic [NUM_REQ-1:0]      last_grant_r;
    logic [NUM_REQ-1:0]      req_ready_r;
    logic                    wr_rd_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [WIDTH-1:0]        wdata_r;
    logic [WIDTH-1:0]        rdata_r;
    logic                    sel_wr_rd_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [WIDTH-1:0]        sel_wdata_s;
    logic                    timeout_s;
    logic                    done_s;

    mem_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_r),
        .grant_o      (pick_s),
        .valid_o      (pick_valid_s)
    );

    // One-hot mux of the picked requester's command fields.
    always_comb begin
        sel_wr_rd_s = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            sel_wr_rd_s = sel_wr_rd_s | (req_wr_rd_i[i] & pick_s[i]);
            sel_addr_s  = sel_addr_s  | (req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{pick_s[i]}});
            sel_wdata_s = sel_wdata_s | (req_wdata_i[i*WIDTH +: WIDTH] & {WIDTH{pick_s[i]}});
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);

    logic [CNT_W-1:0] timeout_cnt_r;
    logic             req_err_r;

    // Counts completed ISSUE cycles; cleared whenever the FSM is idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_cnt_r <= '0;
        end else if (state_r != ISSUE) begin
            timeout_cnt_r <= '0;
        end else begin
            timeout_cnt_r <= timeout_cnt_r + CNT_W'(1'b1);
        end
    end

    // Fires in the last allowed ISSUE cycle so the abort lands after exactly
    // TIMEOUT_CYCLES cycles of valid_o.
    assign timeout_s = (state_r == ISSUE) &&
                       (timeout_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'd1));

    // Error flag pulses with the completion only when ready_i did not win.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_err_r <= 1'b0;
        end else begin
            req_err_r <= timeout_s & ~ready_i;
        end
    end

    assign req_err_o = req_err_r;
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign req_err_o        = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYCLES != 32'd0);
`endif

    assign done_s = (state_r == ISSUE) && (ready_i || timeout_s);

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Registered outputs: command latch on grant, completion/read data on done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_r      <= '0;
            last_grant_r <= LAST_RST_C;
            req_ready_r  <= '0;
            wr_rd_r      <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            rdata_r      <= '0;
        end else begin
            req_ready_r <= '0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r <= pick_s;
                        wr_rd_r <= sel_wr_rd_s;
                        addr_r  <= sel_addr_s;
                        wdata_r <= sel_wdata_s;
                    end
                end
                ISSUE: begin
                    if (done_s) begin
                        req_ready_r  <= grant_r;
                        last_grant_r <= grant_r;
                        grant_r      <= '0;
                        // Aborted or write transactions leave read data untouched.
                        if (ready_i && !wr_rd_r) begin
                            rdata_r <= rdata_i;
                        end
                    end
                end
                default: grant_r <= '0;
            endcase
        end
    end

    assign valid_o     = (state_r == ISSUE);
    assign busy_o      = (state_r == ISSUE);
    assign grant_o     = grant_r;
    assign req_ready_o = req_ready_r;
    assign req_rdata_o = rdata_r;
    assign wr_rd_o     = wr_rd_r;
    assign addr_o      = addr_r;
    assign wdata_o     = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios plus randomized traffic against a transaction-level
// reference model of the arbiter and a behavioural 64-word memory.
// Honours MEM_ARB_TIMEOUT_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int W  = 16;
    localparam int TO = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i, req_wr_rd_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*W-1:0]  req_wdata_i;
    logic [N-1:0]    req_ready_o;
    logic [W-1:0]    req_rdata_o;
    logic            req_err_o, valid_o, wr_rd_o, ready_i, busy_o;
    logic [AW-1:0]   addr_o;
    logic [W-1:0]    wdata_o, rdata_i;
    logic [N-1:0]    grant_o;

    mem_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(64), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_wr_rd_i(req_wr_rd_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .req_rdata_o(req_rdata_o), .req_err_o(req_err_o),
        .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .ready_i(ready_i), .rdata_i(rdata_i), .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // requester-side stimulus
    logic [N-1:0]  rv, rw;
    logic [AW-1:0] ra [N];
    logic [W-1:0]  rd [N];
    bit            rand_mode, auto_rereq;
    int            next_delay;

    // reference model
    logic [W-1:0]  mem [64];
    bit            m_busy, m_wr, m_err;
    int            m_owner, m_last, m_cnt, m_delay;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_wdata, m_rdata;
    logic [N-1:0]  m_pulse;

    // observation
    int            n_checks, n_errors;
    int            n_valid_obs, n_pulse, n_owner0;
    logic [N-1:0]  last_pulse;
    logic [N-1:0]  grant_q [$];
    bit            prev_valid, seen_wr, to_err_seen;
    logic [W-1:0]  seen_wdata;
    logic [AW-1:0] seen_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (i == idx) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_delay = 1;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_pulse = '0; m_err = 1'b0;
    endtask

    task automatic finish_txn(input bit err);
        m_pulse = onehot(m_owner);
        m_err   = err;
        if (!err && !m_wr) m_rdata = rdata_i;
        if (!err && m_wr)  mem[m_addr] = m_wdata;
        m_last = m_owner;
        m_busy = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs just driven.
    task automatic model_update();
        bit found;
        int cand;
        m_pulse = '0;
        m_err   = 1'b0;
        if (m_busy) begin
            m_cnt++;
            if (ready_i) finish_txn(1'b0);
`ifdef MEM_ARB_TIMEOUT_EN
            else if (m_cnt == TO) finish_txn(1'b1);
`endif
        end else begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                cand = (m_last + k) % N;
                if (!found && rv[cand]) begin
                    found = 1'b1;
                    m_owner = cand;
                end
            end
            if (found) begin
                m_busy = 1'b1; m_cnt = 0; m_delay = next_delay;
                m_wr = rw[m_owner]; m_addr = ra[m_owner]; m_wdata = rd[m_owner];
            end
        end
    endtask

    task automatic compare_all();
        check_eq("valid_o", 64'(valid_o), 64'(m_busy));
        check_eq("busy_o", 64'(busy_o), 64'(m_busy));
        check_eq("grant_o", 64'(grant_o), 64'(m_busy ? onehot(m_owner) : 4'b0000));
        check_eq("req_ready_o", 64'(req_ready_o), 64'(m_pulse));
        check_eq("req_err_o", 64'(req_err_o), 64'(m_err));
        check_eq("req_rdata_o", 64'(req_rdata_o), 64'(m_rdata));
        check_eq("cmd", 64'({wr_rd_o, addr_o, wdata_o}), 64'({m_wr, m_addr, m_wdata}));
    endtask

    task automatic new_fields(input int i);
        rw[i] = 1'($urandom);
        ra[i] = AW'($urandom);
        rd[i] = W'($urandom);
    endtask

    // Negedge: compare, record observations, let requesters react.
    task automatic sample();
        @(negedge clk_i);
        compare_all();
        if (valid_o) n_valid_obs++;
        if (valid_o && grant_o[0]) n_owner0++;
        if (|req_ready_o) begin last_pulse = req_ready_o; n_pulse++; end
        if (req_err_o && req_ready_o == 4'b0001) to_err_seen = 1'b1;
        if (valid_o && !prev_valid) grant_q.push_back(grant_o);
        prev_valid = valid_o;
        if (valid_o && grant_o == 4'b0010) begin
            seen_wr = wr_rd_o; seen_wdata = wdata_o; seen_addr = addr_o;
        end
        for (int i = 0; i < N; i++) begin
            if (!rand_mode) begin
                if (m_pulse[i]) rv[i] = auto_rereq;
            end else if (m_pulse[i]) begin
                rv[i] = ($urandom_range(0, 3) == 0);
                if (rv[i]) new_fields(i);
            end else if (!rv[i]) begin
                if ($urandom_range(0, 2) == 0) begin rv[i] = 1'b1; new_fields(i); end
            end else if (m_busy && m_owner == i) begin
                if ($urandom_range(0, 3) == 0) new_fields(i);
                if ($urandom_range(0, 7) == 0) rv[i] = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) rv[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            next_delay = int'($urandom_range(1, 5));
`ifdef MEM_ARB_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) next_delay = 1000;
`endif
        end
    endtask

    // Drive inputs (memory answers after m_delay ISSUE cycles) and take an edge.
    task automatic advance();
        req_valid_i = rv;
        req_wr_rd_i = rw;
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW] = ra[i];
            req_wdata_i[i*W +: W]  = rd[i];
        end
        ready_i = m_busy && (m_cnt + 1 == m_delay);
        rdata_i = mem[m_addr];
        @(posedge clk_i);
        if (rst_i) model_reset();
        else       model_update();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin sample(); advance(); end
    endtask

    task automatic pulse_reset();
        sample();
        rst_i = 1'b1;
        #1;
        model_reset();
        compare_all();
        advance();
        sample();
        rst_i = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; n_valid_obs = 0; n_pulse = 0; n_owner0 = 0;
        last_pulse = '0; prev_valid = 1'b0; seen_wr = 1'b0; to_err_seen = 1'b0;
        seen_wdata = '0; seen_addr = '0;
        rand_mode = 1'b0; auto_rereq = 1'b0; next_delay = 1;
        rv = '0; rw = '0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; end
        for (int a = 0; a < 64; a++) mem[a] = W'($urandom);
        rst_i = 1'b1;
        ready_i = 1'b0; rdata_i = '0;
        req_valid_i = '0; req_wr_rd_i = '0; req_addr_i = '0; req_wdata_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        sample();
        rst_i = 1'b0;
        advance();

        // single read, memory ready in the third ISSUE cycle
        pulse_reset();
        mem[6'h15] = 16'hBEEF;
        rv = 4'b0100; rw[2] = 1'b0; ra[2] = 6'h15; next_delay = 3;
        n_valid_obs = 0; last_pulse = '0;
        advance();
        run(8);
        sample();
        check_eq("rd_valid_cycles", 64'(n_valid_obs), 64'(3));
        check_eq("rd_pulse", 64'(last_pulse), 64'(4'b0100));
        check_eq("rd_data", 64'(req_rdata_o), 64'(16'hBEEF));
        advance();

        // all four requesting continuously, memory ready immediately
        pulse_reset();
        rv = 4'hF; rw = '0;
        for (int i = 0; i < N; i++) ra[i] = AW'(i);
        auto_rereq = 1'b1; next_delay = 1;
        grant_q.delete(); n_pulse = 0;
        advance();
        run(10);
        check_eq("rr_completions", 64'(n_pulse), 64'(5));
        auto_rereq = 1'b0;
        sample(); rv = '0; advance();
        run(6);
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("rr_order%0d", k), 64'(grant_q[k]), 64'(onehot(k % N)));

        // write by requester 1 (fields scrambled mid-ISSUE), then read back by 3
        sample();
        rv = 4'b0010; rw = 4'b0010; ra[1] = 6'h3F; rd[1] = 16'h1234; next_delay = 3;
        advance();
        sample(); advance();
        sample(); ra[1] = 6'h01; rd[1] = 16'h5555; rw[1] = 1'b0; advance();
        run(5);
        sample(); rv = 4'b1000; rw[3] = 1'b0; ra[3] = 6'h3F; next_delay = 2; advance();
        run(5);
        sample();
        check_eq("wr_dir", 64'(seen_wr), 64'(1));
        check_eq("wr_wdata", 64'(seen_wdata), 64'(16'h1234));
        check_eq("wr_addr", 64'(seen_addr), 64'(6'h3F));
        check_eq("rdback", 64'(req_rdata_o), 64'(16'h1234));
        advance();

        // reset while waiting in ISSUE
        sample(); rv = 4'b0100; rw[2] = 1'b0; ra[2] = 6'h05; next_delay = 1000; advance();
        run(3);
        pulse_reset();
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 6'h07; next_delay = 2;
        advance();
        sample();
        check_eq("rst_first_grant", 64'(grant_o), 64'(4'b0001));
        advance();
        run(10);

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never answers requester 0; watchdog aborts, then requester 1
        pulse_reset();
        rv = 4'b0011; rw = '0; ra[0] = 6'h01; ra[1] = 6'h02; next_delay = 1000;
        n_owner0 = 0; to_err_seen = 1'b0; grant_q.delete();
        advance();
        sample(); next_delay = 2; advance();
        run(40);
        check_eq("to_cycles", 64'(n_owner0), 64'(TO));
        check_eq("to_err", 64'(to_err_seen), 64'(1));
        check_eq("to_next_grant", 64'(grant_q[1]), 64'(4'b0010));
`endif

        // randomized traffic
        rand_mode = 1'b1;
        run(3000);
        rand_mode = 1'b0; auto_rereq = 1'b0;
        sample(); rv = '0; advance();
        run(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
